// File: rtl/axi_ar_xbar_rr.sv
// AXI read-address crossbar, NUM_M masters to NUM_S slaves, round-robin arbitration.
// A master is eligible only while it and its decoded slave have no read outstanding.
// The winner is forwarded combinationally; a stalled winner is held in GRANT until
// its handshake completes. The last slave index is the default (catch-all) slave.
module axi_ar_xbar_rr #(
  parameter int unsigned NUM_M     = 2,
  parameter int unsigned NUM_S     = 3,
  parameter int unsigned ID_BITS   = 4,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned LEN_BITS  = 4,
  parameter int unsigned SIZE_BITS = 3,
  parameter logic [(NUM_S-1)*ADDR_BITS-1:0] SLV_BASE = {32'h0001_0000, 32'h0000_0000},
  parameter logic [(NUM_S-1)*ADDR_BITS-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
  localparam int unsigned MID_BITS  = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int unsigned IDS_BITS  = ID_BITS + MID_BITS,
  localparam int unsigned SIDX_BITS = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_M*ID_BITS-1:0]      m_arid,
  input  logic [NUM_M*ADDR_BITS-1:0]    m_araddr,
  input  logic [NUM_M*LEN_BITS-1:0]     m_arlen,
  input  logic [NUM_M*SIZE_BITS-1:0]    m_arsize,
  input  logic [NUM_M*2-1:0]            m_arburst,
  input  logic [NUM_M-1:0]              m_arvalid,
  output logic [NUM_M-1:0]              m_arready,
  input  logic [NUM_M-1:0]              m_rlast,
  input  logic [NUM_M-1:0]              m_rready,
  output logic [NUM_S*IDS_BITS-1:0]     s_arid,
  output logic [NUM_S*ADDR_BITS-1:0]    s_araddr,
  output logic [NUM_S*LEN_BITS-1:0]     s_arlen,
  output logic [NUM_S*SIZE_BITS-1:0]    s_arsize,
  output logic [NUM_S*2-1:0]            s_arburst,
  output logic [NUM_S-1:0]              s_arvalid,
  input  logic [NUM_S-1:0]              s_arready,
  input  logic [NUM_S-1:0]              s_rlast,
  input  logic [NUM_S-1:0]              s_rready
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e               state_q, state_d;
  logic [MID_BITS-1:0]  gnt_q, gnt_d;
  logic [MID_BITS-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NUM_M-1:0]     m_lock_q, m_lock_d;
  logic [NUM_S-1:0]     s_lock_q, s_lock_d;

  logic [SIDX_BITS-1:0] dec [NUM_M];
  logic [NUM_M-1:0]     elig;
  logic                 sel_found;
  logic [MID_BITS-1:0]  sel_idx;
  logic                 grant_pend;
  logic                 fwd_en;
  logic                 fwd_go;
  logic [MID_BITS-1:0]  fwd_idx;
  logic [SIDX_BITS-1:0] fwd_tgt;
  logic                 hs;

  // Address decode: scanning downwards lets the lowest matching window win.
  always_comb begin
    for (int m = 0; m < int'(NUM_M); m++) begin
      dec[m] = SIDX_BITS'(NUM_S - 1);
      for (int s = int'(NUM_S) - 2; s >= 0; s--) begin
        if ((m_araddr[m*ADDR_BITS +: ADDR_BITS] & SLV_MASK[s*ADDR_BITS +: ADDR_BITS]) ==
            SLV_BASE[s*ADDR_BITS +: ADDR_BITS]) begin
          dec[m] = SIDX_BITS'(s);
        end
      end
    end
  end

  // Eligibility: requesting, no read of its own outstanding, target slave idle.
  always_comb begin
    for (int m = 0; m < int'(NUM_M); m++) begin
      elig[m] = m_arvalid[m] & ~m_lock_q[m] & ~s_lock_q[dec[m]];
    end
  end

  // Round-robin pick: first eligible master starting at rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < int'(NUM_M); i++) begin
      if (!sel_found && elig[(int'(rr_ptr_q) + i) % int'(NUM_M)]) begin
        sel_found = 1'b1;
        sel_idx   = MID_BITS'((int'(rr_ptr_q) + i) % int'(NUM_M));
      end
    end
  end

  // Forwarded master: the held owner in GRANT, else this cycle's pick.
  assign grant_pend = (state_q == StGrant);
  assign fwd_en     = grant_pend | sel_found;
  assign fwd_idx    = grant_pend ? gnt_q : sel_idx;
  assign fwd_tgt    = dec[fwd_idx];
  // Gate with rstn so every output is quiet while reset is held.
  assign fwd_go     = fwd_en & rstn;
  assign hs         = fwd_go & m_arvalid[fwd_idx] & s_arready[fwd_tgt];

  // FSM next state: park a stalled winner in GRANT until its handshake.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found && !s_arready[dec[sel_idx]]) begin
          state_d = StGrant;
          gnt_d   = sel_idx;
        end
      end
      StGrant: begin
        if (m_arvalid[gnt_q] && s_arready[dec[gnt_q]]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pointer and lock next state: set on handshake, clear on the last R beat.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    m_lock_d = m_lock_q & ~(m_rready & m_rlast);
    s_lock_d = s_lock_q & ~(s_rready & s_rlast);
    if (hs) begin
      rr_ptr_d          = (int'(fwd_idx) == int'(NUM_M) - 1) ? '0 : fwd_idx + MID_BITS'(1);
      m_lock_d[fwd_idx] = 1'b1;
      s_lock_d[fwd_tgt] = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      m_lock_q <= '0;
      s_lock_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      m_lock_q <= m_lock_d;
      s_lock_q <= s_lock_d;
    end
  end

  // Output mux: only the target slave and the forwarded master see activity.
  always_comb begin
    s_arid    = '0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_arvalid = '0;
    m_arready = '0;
    if (fwd_go) begin
      for (int s = 0; s < int'(NUM_S); s++) begin
        if (fwd_tgt == SIDX_BITS'(s)) begin
          s_arid[s*IDS_BITS +: IDS_BITS]     = {fwd_idx, m_arid[fwd_idx*ID_BITS +: ID_BITS]};
          s_araddr[s*ADDR_BITS +: ADDR_BITS] = m_araddr[fwd_idx*ADDR_BITS +: ADDR_BITS];
          s_arlen[s*LEN_BITS +: LEN_BITS]    = m_arlen[fwd_idx*LEN_BITS +: LEN_BITS];
          s_arsize[s*SIZE_BITS +: SIZE_BITS] = m_arsize[fwd_idx*SIZE_BITS +: SIZE_BITS];
          s_arburst[s*2 +: 2]                = m_arburst[fwd_idx*2 +: 2];
          s_arvalid[s]                       = m_arvalid[fwd_idx];
        end
      end
      m_arready[fwd_idx] = s_arready[fwd_tgt];
    end
  end

endmodule
